// File: rtl/tnoc_flit_if_mux_arbiter.sv
// Packet-level round-robin arbiter that drives the one-hot select of a flit mux.
// A grant is held from head to tail so packets from different requesters never interleave.
module tnoc_flit_if_mux_arbiter #(
  parameter int ENTRIES     = 2,
  parameter int INDEX_WIDTH = $clog2(ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ENTRIES-1:0]     i_request,
  input  logic                   i_flit_valid,
  input  logic                   i_flit_ready,
  input  logic                   i_tail,
  output logic [ENTRIES-1:0]     o_grant,
  output logic [INDEX_WIDTH-1:0] o_owner,
  output logic                   o_busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state_reg, state_next;
  logic [ENTRIES-1:0]     grant_reg, grant_next;
  logic [INDEX_WIDTH-1:0] owner_reg, owner_next;
  logic [INDEX_WIDTH-1:0] ptr_reg, ptr_next;
  logic                   busy_reg, busy_next;

  logic                   transfer;
  logic                   pkt_done;
  logic [INDEX_WIDTH-1:0] ptr_after;
  logic [ENTRIES-1:0]     arb_request;
  logic [INDEX_WIDTH-1:0] arb_ptr;
  logic [INDEX_WIDTH-1:0] arb_winner;
  logic                   arb_found;

  assign transfer  = i_flit_valid & i_flit_ready;
  assign pkt_done  = (state_reg == LOCKED) & transfer & i_tail;
  assign ptr_after = (owner_reg == INDEX_WIDTH'(ENTRIES - 1)) ? '0 : owner_reg + 1'b1;

  // On release the owner is masked and the search starts just past it,
  // which gives a zero-bubble hand-over without a back-to-back repeat winner.
  always_comb begin
    arb_request = i_request;
    arb_ptr     = ptr_reg;
    if (pkt_done) begin
      arb_request[owner_reg] = 1'b0;
      arb_ptr                = ptr_after;
    end
  end

  always_comb begin
    logic [INDEX_WIDTH-1:0] idx;
    idx        = '0;
    arb_found  = 1'b0;
    arb_winner = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      idx = INDEX_WIDTH'((int'(arb_ptr) + k) % ENTRIES);
      if (!arb_found && arb_request[idx]) begin
        arb_found  = 1'b1;
        arb_winner = idx;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    busy_next  = busy_reg;
    case (state_reg)
      IDLE: begin
        if (arb_found) begin
          state_next             = LOCKED;
          grant_next             = '0;
          grant_next[arb_winner] = 1'b1;
          owner_next             = arb_winner;
          busy_next              = 1'b1;
        end
      end
      LOCKED: begin
        if (pkt_done) begin
          ptr_next = ptr_after;
          if (arb_found) begin
            grant_next             = '0;
            grant_next[arb_winner] = 1'b1;
            owner_next             = arb_winner;
            busy_next              = 1'b1;
          end else begin
            state_next = IDLE;
            grant_next = '0;
            owner_next = '0;
            busy_next  = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        owner_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      owner_reg <= '0;
      ptr_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      busy_reg  <= busy_next;
    end
  end

  assign o_grant = grant_reg;
  assign o_owner = owner_reg;
  assign o_busy  = busy_reg;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant_reg));

  a_grant_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg == LOCKED && !pkt_done) |=> $stable(grant_reg));

  a_grant_change: assert property (@(posedge clk) disable iff (!rst_n)
    !$stable(grant_reg) |-> $past(pkt_done || state_reg == IDLE));

endmodule
